// File: rtl/stack_ctrl.sv
// Push/pop sequencer for the descending hardware stack: drives the stack-pointer
// strobes, performs the single-word RAM access and reports data or over/underflow.
module stack_ctrl #(
  parameter logic [31:0] STACK_TOP   = 32'h1C00,
  parameter logic [31:0] STACK_LIMIT = 32'h1800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  input  logic        req_op_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_ready_o,
  output logic        rsp_valid_o,
  output logic        rsp_err_o,
  output logic [31:0] rsp_rdata_o,
  output logic        busy_o,
  input  logic [31:0] stack_addr_i,
  output logic        stack_inc_en_o,
  output logic        stack_dec_en_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  typedef enum logic [2:0] {
    IDLE,
    PUSH_WR,
    PUSH_ADJ,
    POP_ADJ,
    POP_RD,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic        err_q, err_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  // All outputs are decoded from state_q, so an asynchronous reset zeroes them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    err_d          = err_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    req_ready_o    = 1'b0;
    rsp_valid_o    = 1'b0;
    rsp_err_o      = 1'b0;
    stack_inc_en_o = 1'b0;
    stack_dec_en_o = 1'b0;
    mem_addr_o     = 32'h0;
    mem_wdata_o    = 32'h0;
    mem_we_o       = 1'b0;
    mem_re_o       = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (req_op_i) begin
            err_d   = (stack_addr_i >= STACK_TOP);
            state_d = err_d ? RESP : POP_ADJ;
          end else begin
            err_d   = (stack_addr_i < STACK_LIMIT);
            wdata_d = req_wdata_i;
            state_d = err_d ? RESP : PUSH_WR;
          end
        end
      end
      PUSH_WR: begin
        mem_we_o    = 1'b1;
        mem_addr_o  = stack_addr_i;
        mem_wdata_o = wdata_q;
        if (mem_ack_i) state_d = PUSH_ADJ;
      end
      PUSH_ADJ: begin
        stack_dec_en_o = 1'b1;
        state_d        = RESP;
      end
      // Pre-increment: the read address is the pointer after this strobe lands.
      POP_ADJ: begin
        stack_inc_en_o = 1'b1;
        state_d        = POP_RD;
      end
      POP_RD: begin
        mem_re_o   = 1'b1;
        mem_addr_o = stack_addr_i;
        if (mem_ack_i) begin
          rdata_d = mem_rdata_i;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign rsp_rdata_o = rdata_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a stack-pointer register model and a
// wait-state-programmable RAM model; each task checks its own scenario inline.
module tb_stack_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reqValid, reqOp, reqReady, rspValid, rspErr, busy;
  logic [31:0] reqWdata, rspRdata;
  logic [31:0] stackAddr;
  logic        incEn, decEn;
  logic [31:0] memAddr, memWdata, memRdata;
  logic        memWe, memRe, memAck;

  logic        spLoad;
  logic [31:0] spLoadVal;
  logic [31:0] ram [0:4095];
  int          ackDelay;
  int          waitCnt;
  int          incCount, decCount, rspCount, errCount, overlapCount;
  int          testsRun, failCount;

  always #5 clk = ~clk;

  stack_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(reqValid), .req_op_i(reqOp), .req_wdata_i(reqWdata),
    .req_ready_o(reqReady), .rsp_valid_o(rspValid), .rsp_err_o(rspErr),
    .rsp_rdata_o(rspRdata), .busy_o(busy),
    .stack_addr_i(stackAddr), .stack_inc_en_o(incEn), .stack_dec_en_o(decEn),
    .mem_addr_o(memAddr), .mem_wdata_o(memWdata), .mem_we_o(memWe), .mem_re_o(memRe),
    .mem_rdata_i(memRdata), .mem_ack_i(memAck)
  );

  // Stack-pointer register model: resets to the empty-stack value, obeys strobes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) stackAddr <= 32'h1C00;
    else if (spLoad) stackAddr <= spLoadVal;
    else if (decEn) stackAddr <= stackAddr - 32'd1;
    else if (incEn) stackAddr <= stackAddr + 32'd1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) waitCnt <= 0;
    else if ((memWe || memRe) && !memAck) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
  end

  assign memAck   = (memWe || memRe) && (waitCnt == ackDelay);
  assign memRdata = memRe ? ram[memAddr[11:0]] : 32'h0;

  always @(posedge clk) begin
    if (memWe && memAck) ram[memAddr[11:0]] <= memWdata;
    if (incEn) incCount <= incCount + 1;
    if (decEn) decCount <= decCount + 1;
    if (rspValid) rspCount <= rspCount + 1;
    if (rspValid && rspErr) errCount <= errCount + 1;
    if ((incEn && decEn) || (memWe && memRe)) overlapCount <= overlapCount + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic loadSp(input logic [31:0] val);
    spLoad = 1'b1; spLoadVal = val;
    step();
    spLoad = 1'b0;
  endtask

  task automatic issue(input logic op, input logic [31:0] data);
    reqValid = 1'b1; reqOp = op; reqWdata = data;
    step();
    reqValid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    testsRun++; if (reqReady !== 1'b1) begin failCount++; $display("[TB] FAIL reset_ready got %b want 1", reqReady); end
    testsRun++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    testsRun++; if (rspValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_rsp got %b want 0", rspValid); end
    testsRun++; if (rspRdata !== 32'h0) begin failCount++; $display("[TB] FAIL reset_rdata got %h want 0", rspRdata); end
    testsRun++; if ({memWe, memRe, incEn, decEn} !== 4'b0) begin failCount++; $display("[TB] FAIL reset_strobes got %b want 0000", {memWe, memRe, incEn, decEn}); end
    testsRun++; if (memAddr !== 32'h0) begin failCount++; $display("[TB] FAIL reset_addr got %h want 0", memAddr); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_push();
    issue(1'b0, 32'hDEADBEEF);
    testsRun++; if (memWe !== 1'b1) begin failCount++; $display("[TB] FAIL push_we got %b want 1", memWe); end
    testsRun++; if (memAddr !== 32'h1C00) begin failCount++; $display("[TB] FAIL push_addr got %h want 1c00", memAddr); end
    testsRun++; if (memWdata !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL push_wdata got %h want deadbeef", memWdata); end
    testsRun++; if (reqReady !== 1'b0) begin failCount++; $display("[TB] FAIL push_ready got %b want 0", reqReady); end
    step();
    testsRun++; if ({decEn, incEn, memWe} !== 3'b100) begin failCount++; $display("[TB] FAIL push_dec got %b want 100", {decEn, incEn, memWe}); end
    testsRun++; if (memAddr !== 32'h0) begin failCount++; $display("[TB] FAIL push_addr_idle got %h want 0", memAddr); end
    step();
    testsRun++; if ({rspValid, rspErr} !== 2'b10) begin failCount++; $display("[TB] FAIL push_rsp got %b want 10", {rspValid, rspErr}); end
    testsRun++; if (stackAddr !== 32'h1BFF) begin failCount++; $display("[TB] FAIL push_sp got %h want 1bff", stackAddr); end
    step();
    testsRun++; if ({rspValid, reqReady} !== 2'b01) begin failCount++; $display("[TB] FAIL push_done got %b want 01", {rspValid, reqReady}); end
  endtask

  task automatic test_pop();
    issue(1'b1, 32'h0);
    testsRun++; if ({incEn, decEn, memRe} !== 3'b100) begin failCount++; $display("[TB] FAIL pop_inc got %b want 100", {incEn, decEn, memRe}); end
    step();
    testsRun++; if (memRe !== 1'b1) begin failCount++; $display("[TB] FAIL pop_re got %b want 1", memRe); end
    testsRun++; if (memAddr !== 32'h1C00) begin failCount++; $display("[TB] FAIL pop_addr got %h want 1c00", memAddr); end
    step();
    testsRun++; if ({rspValid, rspErr} !== 2'b10) begin failCount++; $display("[TB] FAIL pop_rsp got %b want 10", {rspValid, rspErr}); end
    testsRun++; if (rspRdata !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL pop_rdata got %h want deadbeef", rspRdata); end
    testsRun++; if (stackAddr !== 32'h1C00) begin failCount++; $display("[TB] FAIL pop_sp got %h want 1c00", stackAddr); end
    step();
  endtask

  task automatic test_underflow();
    int incBefore;
    incBefore = incCount;
    issue(1'b1, 32'h0);
    testsRun++; if ({rspValid, rspErr} !== 2'b11) begin failCount++; $display("[TB] FAIL under_rsp got %b want 11", {rspValid, rspErr}); end
    testsRun++; if ({incEn, memRe} !== 2'b00) begin failCount++; $display("[TB] FAIL under_quiet got %b want 00", {incEn, memRe}); end
    step(); step();
    testsRun++; if (incCount !== incBefore) begin failCount++; $display("[TB] FAIL under_strobe got %0d want %0d", incCount, incBefore); end
    testsRun++; if (stackAddr !== 32'h1C00) begin failCount++; $display("[TB] FAIL under_sp got %h want 1c00", stackAddr); end
    testsRun++; if (reqReady !== 1'b1) begin failCount++; $display("[TB] FAIL under_ready got %b want 1", reqReady); end
  endtask

  task automatic test_overflow();
    int decBefore;
    loadSp(32'h17FF);
    decBefore = decCount;
    issue(1'b0, 32'h11111111);
    testsRun++; if ({rspValid, rspErr, memWe} !== 3'b110) begin failCount++; $display("[TB] FAIL over_rsp got %b want 110", {rspValid, rspErr, memWe}); end
    step(); step();
    testsRun++; if (stackAddr !== 32'h17FF) begin failCount++; $display("[TB] FAIL over_sp got %h want 17ff", stackAddr); end
    testsRun++; if (decCount !== decBefore) begin failCount++; $display("[TB] FAIL over_strobe got %0d want %0d", decCount, decBefore); end
    loadSp(32'h1800);
    issue(1'b0, 32'h22222222);
    testsRun++; if ({memWe, memAddr} !== {1'b1, 32'h1800}) begin failCount++; $display("[TB] FAIL limit_wr got %b/%h want 1/1800", memWe, memAddr); end
    step(); step();
    testsRun++; if ({rspValid, rspErr} !== 2'b10) begin failCount++; $display("[TB] FAIL limit_rsp got %b want 10", {rspValid, rspErr}); end
    testsRun++; if (stackAddr !== 32'h17FF) begin failCount++; $display("[TB] FAIL limit_sp got %h want 17ff", stackAddr); end
    testsRun++; if (rspRdata !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL rdata_hold got %h want deadbeef", rspRdata); end
    step();
  endtask

  task automatic test_wait_states();
    loadSp(32'h1A00);
    ackDelay = 3;
    issue(1'b0, 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      testsRun++; if ({memWe, decEn} !== 2'b10) begin failCount++; $display("[TB] FAIL wait_we[%0d] got %b want 10", i, {memWe, decEn}); end
      testsRun++; if ({memAddr, memWdata} !== {32'h1A00, 32'h12345678}) begin failCount++; $display("[TB] FAIL wait_bus[%0d] got %h/%h want 1a00/12345678", i, memAddr, memWdata); end
      step();
    end
    testsRun++; if ({decEn, memWe} !== 2'b10) begin failCount++; $display("[TB] FAIL wait_dec got %b want 10", {decEn, memWe}); end
    step();
    testsRun++; if ({rspValid, rspErr} !== 2'b10) begin failCount++; $display("[TB] FAIL wait_rsp got %b want 10", {rspValid, rspErr}); end
    testsRun++; if (stackAddr !== 32'h19FF) begin failCount++; $display("[TB] FAIL wait_sp got %h want 19ff", stackAddr); end
    step();
  endtask

  task automatic test_reset_mid();
    int rspBefore;
    ackDelay = 5;
    issue(1'b1, 32'h0);
    step();
    testsRun++; if ({memRe, memAddr} !== {1'b1, 32'h1A00}) begin failCount++; $display("[TB] FAIL mid_rd got %b/%h want 1/1a00", memRe, memAddr); end
    #2 rst_n = 1'b0;
    #1;
    testsRun++; if ({memRe, memWe, incEn, decEn, rspValid, rspErr} !== 6'b0) begin failCount++; $display("[TB] FAIL mid_ctl got %b want 000000", {memRe, memWe, incEn, decEn, rspValid, rspErr}); end
    testsRun++; if ({memAddr, rspRdata} !== 64'h0) begin failCount++; $display("[TB] FAIL mid_data got %h/%h want 0/0", memAddr, rspRdata); end
    testsRun++; if ({reqReady, busy} !== 2'b10) begin failCount++; $display("[TB] FAIL mid_idle got %b want 10", {reqReady, busy}); end
    rspBefore = rspCount;
    ackDelay = 0;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step();
    testsRun++; if (rspCount !== rspBefore) begin failCount++; $display("[TB] FAIL mid_norsp got %0d want %0d", rspCount, rspBefore); end
    testsRun++; if ({reqReady, busy} !== 2'b10) begin failCount++; $display("[TB] FAIL mid_after got %b want 10", {reqReady, busy}); end
    testsRun++; if (stackAddr !== 32'h1C00) begin failCount++; $display("[TB] FAIL mid_sp got %h want 1c00", stackAddr); end
  endtask

  task automatic test_back_to_back();
    int incB, decB, rspB, errB, ovB;
    incB = incCount; decB = decCount; rspB = rspCount; errB = errCount; ovB = overlapCount;
    reqValid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      testsRun++; if (busy !== (k % 4 != 0)) begin failCount++; $display("[TB] FAIL b2b_busy[%0d] got %b want %b", k, busy, (k % 4 != 0)); end
      testsRun++; if (rspValid !== (k % 4 == 3)) begin failCount++; $display("[TB] FAIL b2b_rsp[%0d] got %b want %b", k, rspValid, (k % 4 == 3)); end
      if (k % 4 == 0) begin
        reqOp    = ((k / 4) % 2 == 1);
        reqWdata = 32'hA5A50000 + 32'(k);
      end else begin
        reqOp    = ~reqOp;
        reqWdata = 32'hFFFFFFFF;
      end
      step();
    end
    reqValid = 1'b0;
    step();
    testsRun++; if ((incCount - incB) !== 2 || (decCount - decB) !== 2) begin failCount++; $display("[TB] FAIL b2b_strobes got inc %0d dec %0d want 2/2", incCount - incB, decCount - decB); end
    testsRun++; if ((rspCount - rspB) !== 4 || (errCount - errB) !== 0) begin failCount++; $display("[TB] FAIL b2b_rsps got %0d err %0d want 4/0", rspCount - rspB, errCount - errB); end
    testsRun++; if (overlapCount !== ovB) begin failCount++; $display("[TB] FAIL b2b_overlap got %0d want %0d", overlapCount, ovB); end
    testsRun++; if (rspRdata !== 32'hA5A50008) begin failCount++; $display("[TB] FAIL b2b_rdata got %h want a5a50008", rspRdata); end
    testsRun++; if (stackAddr !== 32'h1C00) begin failCount++; $display("[TB] FAIL b2b_sp got %h want 1c00", stackAddr); end
  endtask

  initial begin
    testsRun = 0; failCount = 0;
    incCount = 0; decCount = 0; rspCount = 0; errCount = 0; overlapCount = 0;
    reqValid = 1'b0; reqOp = 1'b0; reqWdata = 32'h0;
    spLoad = 1'b0; spLoadVal = 32'h0; ackDelay = 0;
    for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
    test_reset();
    test_push();
    test_pop();
    test_underflow();
    test_overflow();
    test_wait_states();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Push/pop sequencer for the hardware stack. Sits directly upstream of the base-address register file: it reads the live stack pointer (`stack_addr`) and drives its `stack_inc_en`/`stack_dec_en` strobes. It performs the matching single-word RAM access and returns the popped data or an error to the core's instruction sequencer. The stack is descending, post-decrement on push and pre-increment on pop.

## Interface
- `STACK_TOP`, 32'h1C00: empty-stack pointer value; must equal the stack-pointer reset value.
- `STACK_LIMIT`, 32'h1800: lowest address a push may write. Capacity is STACK_TOP−STACK_LIMIT+1 = 0x401 words.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  operation request.
- `req_op`  in  1  0 = push, 1 = pop.
- `req_wdata`  in  32  push data.
- `req_ready`  out  1  high only in IDLE; a request is accepted when `req_valid && req_ready`.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_err`  out  1  qualifies `rsp_valid`: overflow on push, underflow on pop.
- `rsp_rdata`  out  32  pop data; holds until the next pop response.
- `busy`  out  1  state ≠ IDLE; the sequencer must not write base registers while high.
- `stack_addr`  in  32  current stack pointer.
- `stack_inc_en`  out  1  one-cycle increment strobe to the stack pointer.
- `stack_dec_en`  out  1  one-cycle decrement strobe to the stack pointer.
- `mem_addr`  out  32  RAM word address.
- `mem_wdata`  out  32  RAM write data.
- `mem_we`  out  1  write request; held until `mem_ack`.
- `mem_re`  out  1  read request; held until `mem_ack`.
- `mem_rdata`  in  32  read data, valid in the `mem_ack` cycle.
- `mem_ack`  in  1  access completes this cycle.

## Operation
- **States:** IDLE, PUSH_WR, PUSH_ADJ, POP_ADJ, POP_RD, RESP.
- **Accept:** on acceptance, latch `req_op`, `req_wdata` and an error flag.
  - Push error: `stack_addr < STACK_LIMIT`.
  - Pop error: `stack_addr >= STACK_TOP`.
  - Comparisons are unsigned, 32-bit.
- **Error path:** IDLE → RESP directly. No memory access, no strobe, pointer unchanged.
- **Push:** IDLE → PUSH_WR.
  - `mem_we` = 1, `mem_addr` = `stack_addr`, `mem_wdata` = latched data.
  - On `mem_ack`, go to PUSH_ADJ. PUSH_ADJ asserts `stack_dec_en` for exactly one cycle, then goes to RESP.
- **Pop:** IDLE → POP_ADJ.
  - POP_ADJ asserts `stack_inc_en` for one cycle, then goes to POP_RD.
  - POP_RD: `mem_re` = 1, `mem_addr` = `stack_addr` (already incremented).
  - On `mem_ack`, capture `mem_rdata` into `rsp_rdata`, then go to RESP.
- **RESP:** `rsp_valid` = 1 for one cycle, `rsp_err` = latched flag, then go to IDLE.
- **Output gating:**
  - `stack_inc_en` and `stack_dec_en` are never high together and never high outside POP_ADJ/PUSH_ADJ.
  - `mem_we` and `mem_re` are never high together.
  - `mem_addr` and `mem_wdata` are 0 when no access is in progress.
- **Pointer arithmetic:** owned by the stack-pointer register. A base-register write in the same cycle as a strobe would override the strobe; `busy` exists so the sequencer blocks such writes.
- **No wrap checks:** the pointer is never pushed below STACK_LIMIT−1 or popped above STACK_TOP, so wrap-around cannot occur.

## Timing
- **Reset values:** state IDLE, `req_ready` = 1, `busy` = 0. All other outputs are 0, including `rsp_rdata`.
- **Reset mid-operation:** abort immediately to IDLE. No strobe or `rsp_valid` is issued afterwards. An interrupted pop may already have incremented the pointer; the pointer is reset by the same `rst_n`.
- **Latency with zero-wait memory** (accept in cycle T):
  - Push: T+1 PUSH_WR (ack), T+2 `stack_dec_en`, T+3 `rsp_valid`. The new pointer is visible at T+3.
  - Pop: T+1 `stack_inc_en`, T+2 POP_RD (ack), T+3 `rsp_valid` with data.
  - Error: `rsp_valid` at T+1.
- **Memory wait states:** each cycle without `mem_ack` adds one cycle; address and data are held stable throughout.
- **Back-to-back:** `req_ready` is low from T+1 until the cycle after RESP. The next accept is possible at T+4, so one operation completes per 4 cycles.
- **Requests while busy:** ignored and not queued.

## Test plan
- **Push after reset:** `stack_addr` = 0x1C00, push 0xDEADBEEF.
  - T+1: `mem_we`, `mem_addr` = 0x1C00, `mem_wdata` = 0xDEADBEEF.
  - T+2: `stack_dec_en`.
  - T+3: `rsp_valid`, `rsp_err` = 0.
  - `stack_addr` = 0x1BFF afterwards.
- **Pop after that push:** `stack_addr` = 0x1BFF.
  - T+1: `stack_inc_en`.
  - T+2: `mem_re` at 0x1C00, RAM returns 0xDEADBEEF.
  - T+3: `rsp_valid`, `rsp_rdata` = 0xDEADBEEF, `stack_addr` = 0x1C00.
- **Underflow/overflow:**
  - Pop at `stack_addr` = 0x1C00 → `rsp_valid` and `rsp_err` at T+1; no strobe, no `mem_re`.
  - Push at 0x17FF → error response, pointer unchanged.
  - Push at 0x1800 → succeeds.
- **Wait states:** `mem_ack` delayed 3 cycles on a push.
  - `mem_we`, address and data stay stable for 4 cycles.
  - `stack_dec_en` comes 1 cycle after ack; `rsp_valid` at T+6.
- **Reset mid-operation:** assert `rst_n` low during POP_RD.
  - All outputs 0 asynchronously, state IDLE, `req_ready` = 1 after release.
  - No `rsp_valid` from the aborted operation.
- **Busy rejection:** hold `req_valid` continuously with alternating ops.
  - Accepts only at T, T+4, T+8, …
  - Never more than one strobe per operation; `busy` = 0 exactly in accept cycles.
